// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequences a 1-cycle-latency instruction memory into pc/pc+4 pairs for dual-issue decode.
// Define FETCH_SEQ_PERF_EN to add saturating perf_pairs/perf_redirects/perf_stall_cycles counters.
module fetch_sequencer #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    output logic                          imem_rd_en,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_rdata,
    output logic                          pair_valid,
    output logic [31:0]                   instr1,
    output logic [31:0]                   instr2,
    output logic [31:0]                   pc1,
    output logic [31:0]                   pc2
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [31:0]                   perf_pairs,
    output logic [31:0]                   perf_redirects,
    output logic [31:0]                   perf_stall_cycles
`endif
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        FETCH0 = 2'd0,
        FETCH1 = 2'd1,
        WAIT1  = 2'd2,
        VALID  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [31:0]    pc_r;
    logic [31:0]    pc2_r;
    logic [31:0]    pc_next_s;
    logic [31:0]    pc_plus4_s;
    logic [31:0]    addr_sel_s;
    logic           run_r;
    logic           redirect_s;
    logic           capture1_s;
    logic           capture2_s;
    logic [31:0]    instr1_r;
    logic [31:0]    instr2_r;
    logic           rd_en_r;
    logic [AW-1:0]  addr_r;
    logic           valid_r;

    // Redirect priority, then the normal fill/accept sequence.
    // run_r holds the FSM in FETCH0 for the release edge so the first read follows reset release.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        redirect_s   = branch_taken | flush;
        if (branch_taken) begin
            pc_next_s    = branch_target & 32'hFFFF_FFFC;
            state_next_s = FETCH0;
        end else if (flush) begin
            state_next_s = FETCH0;
        end else begin
            case (state_r)
                FETCH0: begin
                    if (run_r) begin
                        state_next_s = FETCH1;
                    end else begin
                        state_next_s = FETCH0;
                    end
                end
                FETCH1: state_next_s = WAIT1;
                WAIT1:  state_next_s = VALID;
                VALID: begin
                    if (!stall) begin
                        pc_next_s    = pc_r + 32'd8;
                        state_next_s = FETCH0;
                    end else begin
                        state_next_s = VALID;
                    end
                end
                default: state_next_s = FETCH0;
            endcase
        end
        pc_plus4_s = pc_next_s + 32'd4;
        addr_sel_s = (state_next_s == FETCH1) ? pc_plus4_s : pc_next_s;
        capture1_s = (state_r == FETCH1) && !redirect_s;
        capture2_s = (state_r == WAIT1) && !redirect_s;
    end

    // State, program counter, captured pair and registered Moore outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= FETCH0;
            pc_r     <= RESET_PC;
            pc2_r    <= RESET_PC + 32'd4;
            run_r    <= 1'b0;
            instr1_r <= 32'h0000_0000;
            instr2_r <= 32'h0000_0000;
            rd_en_r  <= 1'b0;
            addr_r   <= {AW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            pc_r     <= pc_next_s;
            pc2_r    <= pc_plus4_s;
            run_r    <= 1'b1;
            rd_en_r  <= (state_next_s == FETCH0) || (state_next_s == FETCH1);
            addr_r   <= AW'(addr_sel_s >> 5'd2);
            valid_r  <= (state_next_s == VALID);
            if (capture1_s) begin
                instr1_r <= imem_rdata;
            end
            if (capture2_s) begin
                instr2_r <= imem_rdata;
            end
        end
    end

    assign imem_rd_en = rd_en_r;
    assign imem_addr  = addr_r;
    assign pair_valid = valid_r;
    assign instr1     = instr1_r;
    assign instr2     = instr2_r;
    assign pc1        = pc_r;
    assign pc2        = pc2_r;

`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_pairs_r;
    logic [31:0] perf_redirects_r;
    logic [31:0] perf_stall_cycles_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        if (value == 32'hFFFF_FFFF) begin
            sat_inc = value;
        end else begin
            sat_inc = value + 32'd1;
        end
    endfunction

    // Saturating event counters; a pair shown during a redirect is neither accepted nor stalled.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_pairs_r        <= 32'h0000_0000;
            perf_redirects_r    <= 32'h0000_0000;
            perf_stall_cycles_r <= 32'h0000_0000;
        end else begin
            if (redirect_s) begin
                perf_redirects_r <= sat_inc(perf_redirects_r);
            end
            if ((state_r == VALID) && !redirect_s && !stall) begin
                perf_pairs_r <= sat_inc(perf_pairs_r);
            end
            if ((state_r == VALID) && !redirect_s && stall) begin
                perf_stall_cycles_r <= sat_inc(perf_stall_cycles_r);
            end
        end
    end

    assign perf_pairs        = perf_pairs_r;
    assign perf_redirects    = perf_redirects_r;
    assign perf_stall_cycles = perf_stall_cycles_r;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then randomized traffic vs a phase-based model.
module tb_fetch_sequencer;

    localparam int unsigned D        = 256;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        pair_valid;
    logic [31:0] instr1;
    logic [31:0] instr2;
    logic [31:0] pc1;
    logic [31:0] pc2;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] perf_pairs;
    logic [31:0] perf_redirects;
    logic [31:0] perf_stall_cycles;
`endif

    int total = 0;
    int bad   = 0;

    // reference model: pc of the pair under construction and cycles since its fetch began
    logic [31:0] m_pc;
    int          m_phase;
    bit          m_started;
    int          m_pairs;
    int          m_redir;
    int          m_stalls;

    fetch_sequencer #(
        .IMEM_DEPTH (D),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .pair_valid    (pair_valid),
        .instr1        (instr1),
        .instr2        (instr2),
        .pc1           (pc1),
        .pc2           (pc2)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .perf_pairs        (perf_pairs),
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] idx);
        mem_word = 32'h1000_0000 + (idx % D);
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] byte_addr);
        word_of = (byte_addr >> 2) % D;
    endfunction

    // Memory: data for a read appears the cycle after the strobe; garbage otherwise.
    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? mem_word({24'h0, imem_addr}) : $urandom;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic s, input logic f, input logic b,
                              input logic [31:0] t);
        if (!r) begin
            m_pc = RESET_PC; m_phase = 0; m_started = 1'b0;
            m_pairs = 0; m_redir = 0; m_stalls = 0;
        end else begin
            if (b || f) m_redir++;
            if (m_started && m_phase == 3 && !b && !f) begin
                if (s) m_stalls++;
                else   m_pairs++;
            end
            if (b) begin
                m_pc = t & 32'hFFFF_FFFC; m_phase = 0;
            end else if (f || !m_started) begin
                m_phase = 0;
            end else if (m_phase < 3) begin
                m_phase++;
            end else if (!s) begin
                m_pc = m_pc + 32'd8; m_phase = 0;
            end
            m_started = 1'b1;
        end
    endtask

    task automatic compare_all();
        bit exp_rd;
        bit exp_valid;
        exp_rd    = m_started && (m_phase < 2);
        exp_valid = m_started && (m_phase == 3);
        check("pair_valid", {31'h0, pair_valid}, {31'h0, exp_valid});
        check("rd_en", {31'h0, imem_rd_en}, {31'h0, exp_rd});
        check("pc1", pc1, m_pc);
        check("pc2", pc2, m_pc + 32'd4);
        if (exp_rd) check("addr", {24'h0, imem_addr}, word_of(m_pc + 32'(4 * m_phase)));
        if (exp_valid) begin
            check("instr1", instr1, mem_word(word_of(m_pc)));
            check("instr2", instr2, mem_word(word_of(m_pc + 32'd4)));
        end
`ifdef FETCH_SEQ_PERF_EN
        check("perf_pairs", perf_pairs, 32'(m_pairs));
        check("perf_redirects", perf_redirects, 32'(m_redir));
        check("perf_stalls", perf_stall_cycles, 32'(m_stalls));
`endif
    endtask

    task automatic tick(input logic r, input logic s, input logic f, input logic b,
                        input logic [31:0] t);
        reset = r; stall = s; flush = f; branch_taken = b; branch_target = t;
        model_step(r, s, f, b, t);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to_valid();
        for (int i = 0; i < 16 && !pair_valid; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("reach_valid", {31'h0, pair_valid}, 32'h1);
    endtask

    initial begin
        int n;
        // reset, then first pair latency and contents
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check("rst_instr1", instr1, 32'h0);
        check("rst_instr2", instr2, 32'h0);
        check("rst_rd_en", {31'h0, imem_rd_en}, 32'h0);
        n = 0;
        for (int i = 0; i < 10 && !pair_valid; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
            n++;
        end
        check("first_latency", 32'(n), 32'd4);
        check("first_instr1", instr1, 32'h1000_0000);
        check("first_instr2", instr2, 32'h1000_0001);
        check("first_pc1", pc1, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run_to_valid();
        check("second_pc1", pc1, 32'h8);

        // backpressure for five VALID cycles
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            check("stall_rd_en", {31'h0, imem_rd_en}, 32'h0);
            check("stall_pc1", pc1, 32'h8);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run_to_valid();
        check("post_stall_pc1", pc1, 32'h10);
`ifdef FETCH_SEQ_PERF_EN
        check("perf_stall5", perf_stall_cycles, 32'd5);
`endif

        // branch during FETCH1
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0043);
        check("br_addr", {24'h0, imem_addr}, 32'd16);
        check("br_rd_en", {31'h0, imem_rd_en}, 32'h1);
        run_to_valid();
        check("br_pc1", pc1, 32'h40);
        check("br_instr1", instr1, 32'h1000_0010);

        // wrap at the top of memory
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_03FC);
        check("wrap_addr0", {24'h0, imem_addr}, 32'd255);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("wrap_addr1", {24'h0, imem_addr}, 32'd0);
        run_to_valid();
        check("wrap_instr1", instr1, 32'h1000_00FF);
        check("wrap_instr2", instr2, 32'h1000_0000);
        check("wrap_pc2", pc2, 32'h0000_0400);

        // flush on an offered pair is not an accept
        tick(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0020);
        run_to_valid();
        check("fl_pc1_before", pc1, 32'h20);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("fl_addr", {24'h0, imem_addr}, 32'd8);
        check("fl_valid", {31'h0, pair_valid}, 32'h0);
        check("fl_pc1_after", pc1, 32'h20);

        // branch beats flush
        tick(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0080);
        check("brfl_addr", {24'h0, imem_addr}, 32'd32);

        // reset beats branch
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0080);
        run_to_valid();
        check("rstbr_pc1", pc1, RESET_PC);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r, s, f, b;
            r = ($urandom_range(0, 99) != 0);
            s = ($urandom_range(0, 99) < 40);
            f = ($urandom_range(0, 99) < 6);
            b = ($urandom_range(0, 99) < 6);
            tick(r, s, f, b, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
